// File: rtl/alu_sequencer_pkg.sv
// Shared opcode constants and FSM state encoding for the ALU sequencer.
package alu_sequencer_pkg;

    localparam logic [2:0] OP_PASS_A = 3'd0;
    localparam logic [2:0] OP_PASS_B = 3'd1;
    localparam logic [2:0] OP_ADD    = 3'd2;
    localparam logic [2:0] OP_SUB    = 3'd3;
    localparam logic [2:0] OP_MUL    = 3'd4;
    localparam logic [2:0] OP_DIV    = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/alu_seq_iter.sv
// Iterative W-step datapath: shift-add multiply, plus restoring divide when
// ALU_SEQUENCER_DIV_EN is defined. result_o is valid in the cycle done_o is high.
module alu_seq_iter
    import alu_sequencer_pkg::*;
#(
    parameter int W = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start_i,
    input  logic           step_i,
    input  logic [2:0]     op_i,
    input  logic [W-1:0]   a_i,
    input  logic [W-1:0]   b_i,
    output logic           done_o,
    output logic [3*W-1:0] result_o
);
    localparam int CW = (W > 1) ? $clog2(W) : 1;

    logic [CW-1:0]  cnt_q;
    logic [2*W-1:0] mcand_q, acc_q, acc_nxt;
    logic [W-1:0]   mplier_q;

    assign acc_nxt = acc_q + (mplier_q[0] ? mcand_q : '0);
    assign done_o  = step_i && (cnt_q == CW'(W - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
        end else if (start_i) begin
            cnt_q    <= '0;
            mcand_q  <= {{W{1'b0}}, a_i};
            mplier_q <= b_i;
            acc_q    <= '0;
        end else if (step_i) begin
            cnt_q    <= cnt_q + 1'b1;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            acc_q    <= acc_nxt;
        end
    end

`ifdef ALU_SEQUENCER_DIV_EN
    logic         is_div_q, ge;
    logic [W-1:0] rem_q, quot_q, dvsr_q, rem_nxt, quot_nxt;
    logic [W:0]   trial;

    // Divisor 0 always passes the compare: quotient fills with ones, remainder ends as A.
    always_comb begin
        trial    = {rem_q, quot_q[W-1]};
        ge       = (trial >= {1'b0, dvsr_q});
        rem_nxt  = ge ? W'(trial - {1'b0, dvsr_q}) : W'(trial);
        quot_nxt = W'({quot_q, ge});
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            is_div_q <= 1'b0;
            rem_q    <= '0;
            quot_q   <= '0;
            dvsr_q   <= '0;
        end else if (start_i) begin
            is_div_q <= (op_i == OP_DIV);
            rem_q    <= '0;
            quot_q   <= a_i;
            dvsr_q   <= b_i;
        end else if (step_i) begin
            rem_q    <= rem_nxt;
            quot_q   <= quot_nxt;
        end
    end

    assign result_o = is_div_q ? {{W{1'b0}}, rem_nxt, quot_nxt} : {{W{1'b0}}, acc_nxt};
`else
    logic unused_op;
    assign unused_op = ^op_i;
    assign result_o  = {{W{1'b0}}, acc_nxt};
`endif

endmodule

// File: rtl/alu_sequencer.sv
// Request/response ALU with single-cycle ops and W-cycle multiply (and divide
// when ALU_SEQUENCER_DIV_EN is defined); holds the FSM and result register.
module alu_sequencer
    import alu_sequencer_pkg::*;
#(
    parameter int W = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           req_valid,
    output logic           req_ready,
    input  logic [2:0]     req_op,
    input  logic [W-1:0]   req_a,
    input  logic [W-1:0]   req_b,
    output logic           rsp_valid,
    input  logic           rsp_ready,
    output logic [3*W-1:0] rsp_data,
    output logic           rsp_err,
    output logic           busy
);
    state_e         state_q, state_d;
    logic [3*W-1:0] data_q, data_d, a_ext, b_ext, iter_result;
    logic           err_q, err_d, iter_start, iter_step, iter_done;

    assign a_ext     = {{(2*W){1'b0}}, req_a};
    assign b_ext     = {{(2*W){1'b0}}, req_b};
    assign iter_step = (state_q == ST_EXEC);

    alu_seq_iter #(.W(W)) u_iter (
        .clk      (clk),
        .rst      (rst),
        .start_i  (iter_start),
        .step_i   (iter_step),
        .op_i     (req_op),
        .a_i      (req_a),
        .b_i      (req_b),
        .done_o   (iter_done),
        .result_o (iter_result)
    );

    always_comb begin
        state_d    = state_q;
        data_d     = data_q;
        err_d      = err_q;
        iter_start = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    case (req_op)
                        OP_PASS_A: begin data_d = a_ext;         err_d = 1'b0; state_d = ST_DONE; end
                        OP_PASS_B: begin data_d = b_ext;         err_d = 1'b0; state_d = ST_DONE; end
                        OP_ADD:    begin data_d = a_ext + b_ext; err_d = 1'b0; state_d = ST_DONE; end
                        OP_SUB:    begin data_d = a_ext - b_ext; err_d = 1'b0; state_d = ST_DONE; end
                        OP_MUL:    begin iter_start = 1'b1; err_d = 1'b0; state_d = ST_EXEC; end
`ifdef ALU_SEQUENCER_DIV_EN
                        OP_DIV:    begin iter_start = 1'b1; err_d = (req_b == '0); state_d = ST_EXEC; end
`endif
                        default:   begin data_d = '0; err_d = 1'b1; state_d = ST_DONE; end
                    endcase
                end
            end
            ST_EXEC: begin
                if (iter_done) begin
                    data_d  = iter_result;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (rsp_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            data_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            err_q   <= err_d;
        end
    end

    assign req_ready = (state_q == ST_IDLE);
    assign rsp_valid = (state_q == ST_DONE);
    assign busy      = (state_q != ST_IDLE);
    assign rsp_data  = data_q;
    assign rsp_err   = err_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer: vector table plus multi-cycle corner sequences.
module tb_alu_sequencer;
    localparam int W = 8;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           req_valid = 1'b0, req_ready;
    logic [2:0]     req_op = '0;
    logic [W-1:0]   req_a = '0, req_b = '0;
    logic           rsp_valid, rsp_ready = 1'b0, rsp_err, busy;
    logic [3*W-1:0] rsp_data;

    int n_chk = 0;
    int n_fail = 0;

    typedef struct {
        logic [2:0]  op;
        logic [7:0]  a;
        logic [7:0]  b;
        logic [23:0] exp_d;
        logic        exp_e;
        int          lat;
    } vec_t;

    vec_t vecs[$];

    alu_sequencer #(.W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_ready();
        int t = 0;
        @(negedge clk);
        while (!req_ready && t < 40) begin
            @(negedge clk);
            t++;
        end
        if (!req_ready) chk("ready_timeout", 32'd0, 32'd1);
    endtask

    task automatic consume();
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
    endtask

    // Accept at the next edge, then scramble inputs so only latched values matter.
    task automatic send(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        wait_ready();
        req_op = op; req_a = a; req_b = b; req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0; req_a = ~a; req_b = ~b; req_op = 3'd0;
    endtask

    task automatic run_vec(input vec_t v);
        int k = 0;
        int bad = 0;
        send(v.op, v.a, v.b);
        while (k < 30) begin
            @(negedge clk);
            k++;
            if (rsp_valid) break;
            if (!busy || req_ready) bad++;
        end
        chk($sformatf("latency op%0d", v.op), k, v.lat);
        chk($sformatf("busy_exec op%0d", v.op), bad, 0);
        chk($sformatf("data op%0d a=%0h b=%0h", v.op, v.a, v.b), {8'h0, rsp_data}, {8'h0, v.exp_d});
        chk($sformatf("err op%0d", v.op), {31'h0, rsp_err}, {31'h0, v.exp_e});
        consume();
    endtask

    initial begin
        int k, bad, seen;

        vecs.push_back('{3'd2, 8'hFF, 8'h01, 24'h000100, 1'b0, 1});
        vecs.push_back('{3'd3, 8'h05, 8'h07, 24'hFFFFFE, 1'b0, 1});
        vecs.push_back('{3'd0, 8'hA5, 8'h3C, 24'h0000A5, 1'b0, 1});
        vecs.push_back('{3'd1, 8'hA5, 8'h3C, 24'h00003C, 1'b0, 1});
        vecs.push_back('{3'd3, 8'h07, 8'h05, 24'h000002, 1'b0, 1});
        vecs.push_back('{3'd2, 8'hFF, 8'hFF, 24'h0001FE, 1'b0, 1});
        vecs.push_back('{3'd4, 8'hFF, 8'hFF, 24'h00FE01, 1'b0, 9});
        vecs.push_back('{3'd4, 8'h12, 8'h34, 24'h0003A8, 1'b0, 9});
        vecs.push_back('{3'd6, 8'h12, 8'h34, 24'h000000, 1'b1, 1});
        vecs.push_back('{3'd7, 8'hFF, 8'h01, 24'h000000, 1'b1, 1});
`ifdef ALU_SEQUENCER_DIV_EN
        vecs.push_back('{3'd5, 8'h64, 8'h07, 24'h00020E, 1'b0, 9});
        vecs.push_back('{3'd5, 8'h64, 8'h00, 24'h0064FF, 1'b1, 9});
        vecs.push_back('{3'd5, 8'hFF, 8'h10, 24'h000F0F, 1'b0, 9});
`else
        vecs.push_back('{3'd5, 8'h64, 8'h07, 24'h000000, 1'b1, 1});
`endif

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst rsp_valid", {31'h0, rsp_valid}, 32'd0);
        chk("rst rsp_err", {31'h0, rsp_err}, 32'd0);
        chk("rst rsp_data", {8'h0, rsp_data}, 32'd0);
        chk("rst busy", {31'h0, busy}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("ready after rst", {31'h0, req_ready}, 32'd1);

        foreach (vecs[i]) run_vec(vecs[i]);

        // Multiply with a request presented mid-EXEC that must be dropped
        send(3'd4, 8'hFF, 8'hFF);
        bad = 0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (!busy || req_ready || rsp_valid) bad++;
            if (c == 3) begin req_valid = 1'b1; req_op = 3'd0; req_a = 8'h11; end
            if (c == 5) req_valid = 1'b0;
        end
        chk("mul busy cycles 1-8", bad, 0);
        @(negedge clk);
        chk("mul rsp_valid c9", {31'h0, rsp_valid}, 32'd1);
        chk("mul data c9", {8'h0, rsp_data}, 32'h00FE01);
        consume();
        seen = 0;
        repeat (3) begin
            @(negedge clk);
            if (rsp_valid || busy) seen++;
        end
        chk("ignored req not queued", seen, 0);

        // Backpressure: result held stable, no same-cycle turnaround
        send(3'd1, 8'h00, 8'h2A);
        bad = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (!rsp_valid || rsp_data !== 24'h00002A) bad++;
        end
        chk("held data stable", bad, 0);
        rsp_ready = 1'b1;
        #1;
        chk("ready in handshake cycle", {31'h0, req_ready}, 32'd0);
        @(posedge clk);
        #1 rsp_ready = 1'b0;
        @(negedge clk);
        chk("ready after handshake", {31'h0, req_ready}, 32'd1);
        chk("valid after handshake", {31'h0, rsp_valid}, 32'd0);

        // Reset during multiply abandons it
        send(3'd4, 8'h0F, 8'h0F);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("ready after mid-exec rst", {31'h0, req_ready}, 32'd1);
        chk("busy after mid-exec rst", {31'h0, busy}, 32'd0);
        seen = 0;
        k = 0;
        while (k < 12) begin
            @(negedge clk);
            if (rsp_valid) seen++;
            k++;
        end
        chk("no rsp after rst", seen, 0);

        // Block still functional after abandoned op
        send(3'd2, 8'h10, 8'h20);
        @(negedge clk);
        chk("post-rst add valid", {31'h0, rsp_valid}, 32'd1);
        chk("post-rst add data", {8'h0, rsp_data}, 32'h000030);
        consume();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 The block SHALL have parameter W, default 8, meaning operand width in bits; the result width is 3*W.
REQ-002 The block SHALL have port clk  input  1  sole clock; all state SHALL change on its rising edge.
REQ-003 The block SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 The block SHALL have port req_valid  input  1  an operation request is present.
REQ-005 The block SHALL have port req_ready  output  1  the block accepts a request this cycle.
REQ-006 The block SHALL have port req_op  input  3  opcode.
REQ-007 The block SHALL have ports req_a and req_b  input  W each  operands.
REQ-008 The block SHALL have port rsp_valid  output  1  a result is held.
REQ-009 The block SHALL have port rsp_ready  input  1  the consumer takes the result.
REQ-010 The block SHALL have port rsp_data  output  3*W  result.
REQ-011 The block SHALL have port rsp_err  output  1  illegal opcode or divide-by-zero.
REQ-012 The block SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-013 The state machine SHALL have exactly three states:
- IDLE: req_ready=1.
- EXEC: multi-cycle operation in progress.
- DONE: rsp_valid=1.
REQ-014 A request SHALL be accepted only when req_valid&&req_ready; the opcode and operands SHALL be latched at acceptance, and input changes afterwards SHALL have no effect.
REQ-015 Opcodes SHALL be decoded as follows:
- 0: A, zero-extended.
- 1: B, zero-extended.
- 2: A+B, zero-extended.
- 3: A-B, as a 3*W-bit two's-complement value.
- 4: A*B, unsigned, 2W bits, zero-extended.
- 5: divide (see Configuration).
- 6, 7: illegal.
REQ-016 Opcodes 0-3 and illegal opcodes SHALL go IDLE->DONE, so rsp_valid rises on the cycle after acceptance (latency 1).
REQ-017 Opcode 4 SHALL go IDLE->EXEC and run as an iterative shift-add over exactly W cycles, with rsp_valid rising W+1 cycles after acceptance.
REQ-018 The EXEC iteration counter SHALL count 0..W-1, and EXEC SHALL move to DONE when the counter equals W-1.
REQ-019 An illegal opcode SHALL produce rsp_data=0 and rsp_err=1; every legal non-error result SHALL produce rsp_err=0.
REQ-020 In DONE, rsp_data and rsp_err SHALL stay stable until rsp_valid&&rsp_ready; that handshake SHALL move the block to IDLE.
REQ-021 req_ready SHALL be 0 in the cycle in which the response is consumed; there is no same-cycle turnaround, so the next acceptance is possible at the earliest one cycle later.
REQ-022 req_ready SHALL be 0 in EXEC and in DONE, and requests presented in those states SHALL be ignored and not queued.

Reset
REQ-023 While rst=1 the block SHALL go to IDLE, clear the counter, and drive rsp_valid=0, rsp_err=0, rsp_data=0 and busy=0.
REQ-024 Because reset is synchronous, req_ready SHALL read 1 in the first cycle after rst deasserts.
REQ-025 Asserting rst during EXEC or DONE SHALL abandon the operation and produce no response.

Configuration
REQ-026 Macro ALU_SEQUENCER_DIV_EN SHALL compile in opcode 5, a W-cycle unsigned restoring divide with the same latency as opcode 4.
REQ-027 The divide result SHALL place the quotient in rsp_data[W-1:0] and the remainder in rsp_data[2W-1:W], with the upper bits 0.
REQ-028 A divide with B=0 SHALL return quotient all-ones, remainder A and rsp_err=1.
REQ-029 Without ALU_SEQUENCER_DIV_EN, opcode 5 SHALL be illegal as in REQ-019, and no divider logic SHALL be present.

Structure
REQ-030 Package alu_sequencer_pkg SHALL hold the opcode constants (OP_PASS_A, OP_PASS_B, OP_ADD, OP_SUB, OP_MUL, OP_DIV) and the state encoding.
REQ-031 The iterative multiply/divide datapath SHALL be the sub-module alu_seq_iter, with start, op and operands in, and done and result out; alu_sequencer SHALL hold the FSM, the handshakes and the result register.

Verification
REQ-032 The bench SHALL check: W=8, op 2, A=0xFF, B=0x01, accepted at cycle 0 -> rsp_data=0x000100 and rsp_valid at cycle 1.
REQ-033 The bench SHALL check: op 3, A=0x05, B=0x07 -> rsp_data=0xFFFFFE and rsp_err=0.
REQ-034 The bench SHALL check: op 4, A=0xFF, B=0xFF -> rsp_data=0x00FE01 at cycle 9; busy=1 and req_ready=0 during cycles 1-8; a request presented at cycle 4 is ignored.
REQ-035 The bench SHALL check: op 1, B=0x2A, with rsp_ready held 0 for 5 cycles -> rsp_data stays 0x00002A; after the handshake, req_ready=0 in the handshake cycle and req_ready=1 in the next cycle.
REQ-036 The bench SHALL check: op 6 -> rsp_data=0 and rsp_err=1; op 4 with rst asserted at cycle 3 -> rsp_valid never rises and req_ready=1 on the cycle after rst falls.
REQ-037 The bench SHALL check, with ALU_SEQUENCER_DIV_EN defined: op 5, A=0x64, B=0x07 -> rsp_data=0x00020E; op 5, B=0 -> rsp_data=0x0064FF and rsp_err=1.
